// File: rtl/mdc8p_stage2.sv
// Second radix-2 DIF stage of the 8-point, 2-lane MDC FFT: one lane butterfly per cycle,
// trivial W4 rotation (+/-j) on odd positions and a one-deep delay-commutator.
module mdc8p_stage2 #(
    parameter int NB_INPUT  = 10,
    parameter int NBF_INPUT = 7,
    parameter int NB_OUTPUT = 11
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_inverse,
    input  logic                        i_valid,
    input  logic signed [NB_INPUT-1:0]  i_data1_r,
    input  logic signed [NB_INPUT-1:0]  i_data1_i,
    input  logic signed [NB_INPUT-1:0]  i_data2_r,
    input  logic signed [NB_INPUT-1:0]  i_data2_i,
    output logic                        o_valid,
    output logic signed [NB_OUTPUT-1:0] o_data1_r,
    output logic signed [NB_OUTPUT-1:0] o_data1_i,
    output logic signed [NB_OUTPUT-1:0] o_data2_r,
    output logic signed [NB_OUTPUT-1:0] o_data2_i
);

    localparam int NB_FLY = NB_INPUT + 1;

    if (NB_OUTPUT < NB_INPUT + 1 || NBF_INPUT >= NB_INPUT) begin : g_param_check
        $error("mdc8p_stage2: need NB_OUTPUT >= NB_INPUT+1 and NBF_INPUT < NB_INPUT");
    end

    function automatic logic signed [NB_FLY-1:0] to_fly(input logic signed [NB_INPUT-1:0] x);
        return NB_FLY'(x);
    endfunction

    function automatic logic signed [NB_OUTPUT-1:0] to_out(input logic signed [NB_FLY-1:0] x);
        return NB_OUTPUT'(x);
    endfunction

    logic                       in_valid_q;
    logic signed [NB_INPUT-1:0] in_a_r_q, in_a_i_q, in_b_r_q, in_b_i_q;
    logic                       par_q;

    logic signed [NB_FLY-1:0]   bf_s_r_s, bf_s_i_s, bf_d_r_s, bf_d_i_s;
    logic signed [NB_FLY-1:0]   rot_r_s, rot_i_s;

    logic                       fly_valid_q, fly_par_q;
    logic signed [NB_FLY-1:0]   fly_s_r_q, fly_s_i_q, fly_d_r_q, fly_d_i_q;

    logic                       pend_valid_q, pend_valid_d;
    logic signed [NB_FLY-1:0]   pend_s_r_q, pend_s_i_q, pend_d_r_q, pend_d_i_q;
    logic signed [NB_FLY-1:0]   pend_s_r_d, pend_s_i_d, pend_d_r_d, pend_d_i_d;
    logic signed [NB_FLY-1:0]   odd_d_r_q, odd_d_i_q, odd_d_r_d, odd_d_i_d;
    logic                       b_due_q, b_due_d;
    logic                       cm_valid_q, cm_valid_d;
    logic signed [NB_FLY-1:0]   cm1_r_q, cm1_i_q, cm2_r_q, cm2_i_q;
    logic signed [NB_FLY-1:0]   cm1_r_d, cm1_i_d, cm2_r_d, cm2_i_d;

    logic                       out_valid_q;
    logic signed [NB_OUTPUT-1:0] out1_r_q, out1_i_q, out2_r_q, out2_i_q;

    // Input register: sample pair and its valid flag, every cycle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            in_valid_q <= 1'b0;
            in_a_r_q   <= '0;
            in_a_i_q   <= '0;
            in_b_r_q   <= '0;
            in_b_i_q   <= '0;
        end else begin
            in_valid_q <= i_valid;
            in_a_r_q   <= i_data1_r;
            in_a_i_q   <= i_data1_i;
            in_b_r_q   <= i_data2_r;
            in_b_i_q   <= i_data2_i;
        end
    end

    // Butterfly and odd-position rotation by -j (forward) or +j (inverse).
    always_comb begin
        bf_s_r_s = to_fly(in_a_r_q) + to_fly(in_b_r_q);
        bf_s_i_s = to_fly(in_a_i_q) + to_fly(in_b_i_q);
        bf_d_r_s = to_fly(in_a_r_q) - to_fly(in_b_r_q);
        bf_d_i_s = to_fly(in_a_i_q) - to_fly(in_b_i_q);
        rot_r_s  = bf_d_r_s;
        rot_i_s  = bf_d_i_s;
        if (par_q) begin
            if (i_inverse) begin
                rot_r_s = -bf_d_i_s;
                rot_i_s = bf_d_r_s;
            end else begin
                rot_r_s = bf_d_i_s;
                rot_i_s = -bf_d_r_s;
            end
        end else begin
            rot_r_s = bf_d_r_s;
            rot_i_s = bf_d_i_s;
        end
    end

    // Fly register plus position parity; parity only advances on valid samples.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            fly_valid_q <= 1'b0;
            fly_par_q   <= 1'b0;
            fly_s_r_q   <= '0;
            fly_s_i_q   <= '0;
            fly_d_r_q   <= '0;
            fly_d_i_q   <= '0;
            par_q       <= 1'b0;
        end else begin
            fly_valid_q <= in_valid_q;
            fly_par_q   <= par_q;
            fly_s_r_q   <= bf_s_r_s;
            fly_s_i_q   <= bf_s_i_s;
            fly_d_r_q   <= rot_r_s;
            fly_d_i_q   <= rot_i_s;
            if (in_valid_q) begin
                par_q <= ~par_q;
            end
        end
    end

    // Commutator: hold even result, emit sums with the odd partner, then differences.
    // A new even may land in the pending slot on the same edge its old d is emitted.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_s_r_d   = pend_s_r_q;
        pend_s_i_d   = pend_s_i_q;
        pend_d_r_d   = pend_d_r_q;
        pend_d_i_d   = pend_d_i_q;
        odd_d_r_d    = odd_d_r_q;
        odd_d_i_d    = odd_d_i_q;
        b_due_d      = 1'b0;
        cm_valid_d   = 1'b0;
        cm1_r_d      = cm1_r_q;
        cm1_i_d      = cm1_i_q;
        cm2_r_d      = cm2_r_q;
        cm2_i_d      = cm2_i_q;
        if (b_due_q) begin
            cm_valid_d   = 1'b1;
            cm1_r_d      = pend_d_r_q;
            cm1_i_d      = pend_d_i_q;
            cm2_r_d      = odd_d_r_q;
            cm2_i_d      = odd_d_i_q;
            pend_valid_d = 1'b0;
        end else begin
            cm_valid_d   = 1'b0;
        end
        if (fly_valid_q) begin
            if (!fly_par_q) begin
                pend_valid_d = 1'b1;
                pend_s_r_d   = fly_s_r_q;
                pend_s_i_d   = fly_s_i_q;
                pend_d_r_d   = fly_d_r_q;
                pend_d_i_d   = fly_d_i_q;
            end else if (pend_valid_q) begin
                cm_valid_d = 1'b1;
                cm1_r_d    = pend_s_r_q;
                cm1_i_d    = pend_s_i_q;
                cm2_r_d    = fly_s_r_q;
                cm2_i_d    = fly_s_i_q;
                odd_d_r_d  = fly_d_r_q;
                odd_d_i_d  = fly_d_i_q;
                b_due_d    = 1'b1;
            end else begin
                b_due_d    = 1'b0;
            end
        end else begin
            b_due_d = b_due_d;
        end
    end

    // Commutator state registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pend_valid_q <= 1'b0;
            pend_s_r_q   <= '0;
            pend_s_i_q   <= '0;
            pend_d_r_q   <= '0;
            pend_d_i_q   <= '0;
            odd_d_r_q    <= '0;
            odd_d_i_q    <= '0;
            b_due_q      <= 1'b0;
            cm_valid_q   <= 1'b0;
            cm1_r_q      <= '0;
            cm1_i_q      <= '0;
            cm2_r_q      <= '0;
            cm2_i_q      <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_s_r_q   <= pend_s_r_d;
            pend_s_i_q   <= pend_s_i_d;
            pend_d_r_q   <= pend_d_r_d;
            pend_d_i_q   <= pend_d_i_d;
            odd_d_r_q    <= odd_d_r_d;
            odd_d_i_q    <= odd_d_i_d;
            b_due_q      <= b_due_d;
            cm_valid_q   <= cm_valid_d;
            cm1_r_q      <= cm1_r_d;
            cm1_i_q      <= cm1_i_d;
            cm2_r_q      <= cm2_r_d;
            cm2_i_q      <= cm2_i_d;
        end
    end

    // Output registers with sign extension to the output word.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            out_valid_q <= 1'b0;
            out1_r_q    <= '0;
            out1_i_q    <= '0;
            out2_r_q    <= '0;
            out2_i_q    <= '0;
        end else begin
            out_valid_q <= cm_valid_q;
            out1_r_q    <= to_out(cm1_r_q);
            out1_i_q    <= to_out(cm1_i_q);
            out2_r_q    <= to_out(cm2_r_q);
            out2_i_q    <= to_out(cm2_i_q);
        end
    end

    assign o_valid   = out_valid_q;
    assign o_data1_r = out1_r_q;
    assign o_data1_i = out1_i_q;
    assign o_data2_r = out2_r_q;
    assign o_data2_i = out2_i_q;

endmodule

// File: doc/mdc8p_stage2.md
# mdc8p_stage2

Second radix-2 DIF stage of the 8-point, 2-lane MDC FFT. It sits directly downstream of stage 1 and consumes stage 1's two-lane commutated stream. On each input cycle it computes one butterfly across the two lanes and applies the trivial W4 twiddle: 1 on even positions, ∓j on odd positions. A one-deep delay-commutator (L=1) then reorders the results for the final stage. No multiplier is used; rotation by ±j is a swap plus a negate.

## Interface
Parameters:
- NB_INPUT, 10, input word width, two's complement.
- NBF_INPUT, 7, input fractional bits (informational; the block does not rescale).
- NB_OUTPUT, 11, output word width. Must be ≥ NB_INPUT+1; results are sign-extended to it.

Ports:
- i_clk, in, 1, clock; all state updates on the rising edge.
- i_rst, in, 1, asynchronous active-low reset.
- i_inverse, in, 1, 0 = forward (odd rotation −j), 1 = inverse (odd rotation +j). Must be static within a frame.
- i_valid, in, 1, input sample pair valid.
- i_data1_r, i_data1_i, in, NB_INPUT, lane 0 (a) real/imag.
- i_data2_r, i_data2_i, in, NB_INPUT, lane 1 (b) real/imag.
- o_valid, out, 1, output pair valid.
- o_data1_r, o_data1_i, o_data2_r, o_data2_i, out, NB_OUTPUT, output lanes 0/1.

## Operation
- Input register: captures a, b and i_valid every cycle.
- Position parity bit p:
  - Toggles on every registered valid sample; holds during gaps.
  - Reset sets p = 0, so the first valid sample after reset is even.
- Butterfly, NB_FLY = NB_INPUT+1, exact with no rounding or saturation: s = a+b, d = a−b.
- Rotation of d, odd positions only:
  - Forward: (dr, di) → (di, −dr).
  - Inverse: (dr, di) → (−di, dr).
  - |d| ≤ 2^NB_INPUT − 1, so negation never overflows NB_FLY.
- Fly register: holds s, rotated d, valid and parity.
- Commutator, L=1:
  - An even result is held in a pending register.
  - When the odd partner arrives, emit pair A = {lane0 = s_even, lane1 = s_odd}.
  - On the next cycle, emit pair B = {lane0 = d_even, lane1 = d_odd(rotated)}. The odd d is kept one extra cycle for this.
- Output registers carry sign-extended values and o_valid.
- Frame = 4 input pairs (positions 0..3) producing 4 output pairs, ordered A(0,1), B(0,1), A(2,3), B(2,3).
- Reset asserted at any time clears all state, including a pending even result; that result is never emitted.

## Timing
- Reset values: o_valid = 0, all o_data = 0, p = 0, pending flag clear.
- Let the odd sample be registered as valid at input edge T:
  - Pair A appears on the outputs at T+3.
  - Pair B appears at T+4.
  - With continuous input, the even sample's latency is 4 cycles to A and 5 cycles to B.
- Continuous i_valid gives continuous o_valid once the pipe fills (first output 4 cycles after the first sample). The output cadence is one pair per cycle.
- Gaps are allowed anywhere, including between the even and odd sample of a pair:
  - p and the pending register hold through the gap.
  - o_valid is low except in the A/B cycles.
- The next A can never collide with the preceding B: the earliest next odd sample is T+2, so its A lands at T+5.
- i_inverse is sampled at the fly stage.
- Deassertion of i_rst is synchronised by the integrator; the block only requires async assertion.

## Test plan
- Reset: hold i_rst=0 with random inputs → all outputs 0 and o_valid=0. After release, idle inputs → o_valid stays 0.
- Forward pair: drive even a=(100,0), b=(20,0), then odd a=(50,10), b=(30,−10), with i_inverse=0.
  - At even+4: A = lane0 (120,0), lane1 (80,0).
  - At even+5: B = lane0 (80,0), lane1 (20,−20).
- Inverse: same stimulus with i_inverse=1 → B lane1 = (−20,20); everything else is unchanged.
- Gap inside a pair: drive the even sample, 3 idle cycles, then the odd sample → A at odd+3 and B at odd+4, o_valid low at all other cycles. Values are identical to the forward test.
- Streaming with extremes: 2 back-to-back frames (8 pairs) including a=(511,−512), b=(−512,511).
  - o_valid is high for exactly 8 consecutive cycles.
  - Order is A0,1 B0,1 A2,3 B2,3 per frame.
  - The extreme pair gives s=(−1,−1) and d=(1023,−1023). At an odd position, forward rotation gives (−1023,−1023), bit-exact with no wrap.
- Reset mid-pair: drive the even sample, pulse i_rst low for 1 cycle, then drive a new even/odd pair → only the new pair's A/B are emitted, and p restarts at even.
